// File: rtl/reg_writeback_queue.sv
// Register-file write-back serialiser: merges ALU and load/mul results onto the single
// write port through an output register and a small FIFO, with pending/forward lookup.
module reg_writeback_queue #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     src0_valid,
   output logic                     src0_ready,
   input  logic [ADDRESS_WIDTH-1:0] src0_rd,
   input  logic [DATA_WIDTH-1:0]    src0_data,
   input  logic                     src1_valid,
   output logic                     src1_ready,
   input  logic [ADDRESS_WIDTH-1:0] src1_rd,
   input  logic [DATA_WIDTH-1:0]    src1_data,
   input  logic [ADDRESS_WIDTH-1:0] ad1,
   input  logic [ADDRESS_WIDTH-1:0] ad2,
   output logic                     pend1,
   output logic                     pend2,
   output logic [DATA_WIDTH-1:0]    fwd1,
   output logic [DATA_WIDTH-1:0]    fwd2,
   output logic                     WE3,
   output logic [ADDRESS_WIDTH-1:0] ad3,
   output logic [DATA_WIDTH-1:0]    WD3,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] rd;
      logic [DATA_WIDTH-1:0]    data;
   } wr_t;

   wr_t                r_mem [DEPTH];
   logic [PW-1:0]      r_wptr, r_rptr;
   logic [CW-1:0]      r_count;

   wr_t                w_e0, w_e1, w_push_a;
   logic               w_acc0, w_acc1, w_pop, w_push_a_v, w_push_b_v;
   logic [1:0]         w_pend;
   logic [ADDRESS_WIDTH-1:0] w_ad  [2];
   logic [DATA_WIDTH-1:0]    w_fwd [2];

   assign src0_ready = (r_count < CW'(DEPTH));
   // src1 only gets the last free slot when src0 is not competing for it
   assign src1_ready = (r_count <= CW'(DEPTH-2)) ||
                       ((r_count == CW'(DEPTH-1)) && !src0_valid);

   assign w_acc0 = src0_valid && src0_ready && (src0_rd != '0);
   assign w_acc1 = src1_valid && src1_ready && (src1_rd != '0);
   assign w_e0   = '{rd: src0_rd, data: src0_data};
   assign w_e1   = '{rd: src1_rd, data: src1_data};
   assign w_pop  = (r_count != '0);
   assign count  = r_count;

   // Whatever the output register does not take goes to the tail, src0 first.
   always_comb begin
      w_push_a_v = 1'b0;
      w_push_b_v = 1'b0;
      w_push_a   = w_e1;
      if (w_pop) begin
         if (w_acc0) begin
            w_push_a_v = 1'b1;
            w_push_a   = w_e0;
            w_push_b_v = w_acc1;
         end else begin
            w_push_a_v = w_acc1;
         end
      end else if (w_acc0) begin
         w_push_a_v = w_acc1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_a_v) r_mem[r_wptr]           <= w_push_a;
      if (w_push_b_v) r_mem[r_wptr + PW'(1)]  <= w_e1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         WE3     <= 1'b0;
         ad3     <= '0;
         WD3     <= '0;
      end else begin
         r_wptr  <= r_wptr + PW'(w_push_a_v) + PW'(w_push_b_v);
         r_count <= r_count + CW'(w_push_a_v) + CW'(w_push_b_v) - CW'(w_pop);
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
            WE3    <= 1'b1;
            ad3    <= r_mem[r_rptr].rd;
            WD3    <= r_mem[r_rptr].data;
         end else if (w_acc0) begin
            WE3 <= 1'b1;
            ad3 <= src0_rd;
            WD3 <= src0_data;
         end else if (w_acc1) begin
            WE3 <= 1'b1;
            ad3 <= src1_rd;
            WD3 <= src1_data;
         end else begin
            WE3 <= 1'b0;
         end
      end
   end

   assign w_ad[0] = ad1;
   assign w_ad[1] = ad2;

   // Oldest first so later (younger) matches overwrite; output register is oldest of all.
   always_comb begin
      w_pend   = '0;
      w_fwd[0] = '0;
      w_fwd[1] = '0;
      for (int p = 0; p < 2; p++) begin
         if (WE3 && (ad3 == w_ad[p])) begin
            w_pend[p] = 1'b1;
            w_fwd[p]  = WD3;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_mem[r_rptr + PW'(i)].rd == w_ad[p])) begin
               w_pend[p] = 1'b1;
               w_fwd[p]  = r_mem[r_rptr + PW'(i)].data;
            end
         end
         if (w_ad[p] == '0) begin
            w_pend[p] = 1'b0;
            w_fwd[p]  = '0;
         end
      end
   end

   assign pend1 = w_pend[0];
   assign pend2 = w_pend[1];
   assign fwd1  = w_fwd[0];
   assign fwd2  = w_fwd[1];

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed vector table, hand sequences for fill/forward/reset,
// and a random phase, all scored against a queue model of pending writes.
module tb_reg_writeback_queue;
   logic        clk = 1'b0;
   logic        rst;
   logic        src0_valid, src1_valid, src0_ready, src1_ready;
   logic [4:0]  src0_rd, src1_rd, ad1, ad2, ad3;
   logic [31:0] src0_data, src1_data, fwd1, fwd2, WD3;
   logic        pend1, pend2, WE3;
   logic [2:0]  count;

   reg_writeback_queue #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_rd(src0_rd), .src0_data(src0_data),
      .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_rd(src1_rd), .src1_data(src1_data),
      .ad1(ad1), .ad2(ad2), .pend1(pend1), .pend2(pend2), .fwd1(fwd1), .fwd2(fwd2),
      .WE3(WE3), .ad3(ad3), .WD3(WD3), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
   typedef struct {
      logic v0; logic [4:0] r0; logic [31:0] d0;
      logic v1; logic [4:0] r1; logic [31:0] d1;
      logic e_we; logic [4:0] e_ad; logic [31:0] e_wd; int e_cnt;
   } vec_t;

   ent_t        sb[$];
   logic        o_v;
   logic [4:0]  o_rd;
   logic [31:0] o_d;
   int          errors = 0;
   int          checks = 0;
   vec_t        tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void exp_lk(input logic [4:0] a, output logic p, output logic [31:0] f);
      p = 1'b0; f = '0;
      if (a != 0) begin
         if (o_v && o_rd == a) begin p = 1'b1; f = o_d; end
         foreach (sb[i]) if (sb[i].rd == a) begin p = 1'b1; f = sb[i].d; end
      end
   endfunction

   // Called at a negedge: drive, check readiness, advance one edge, check outputs at next negedge.
   task automatic tick(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1);
      logic e0, e1, ep;
      logic [31:0] ef;
      int mc;
      src0_valid = v0; src0_rd = r0; src0_data = d0;
      src1_valid = v1; src1_rd = r1; src1_data = d1;
      #1;
      mc = sb.size();
      e0 = (mc < 4);
      e1 = (mc <= 2) || (mc == 3 && !v0);
      chk("src0_ready", src0_ready, e0);
      chk("src1_ready", src1_ready, e1);
      if (v0 && e0 && r0 != 0) sb.push_back({r0, d0});
      if (v1 && e1 && r1 != 0) sb.push_back({r1, d1});
      @(posedge clk);
      if (sb.size() > 0) begin
         ent_t e;
         e = sb.pop_front();
         o_v = 1'b1; o_rd = e.rd; o_d = e.d;
      end else begin
         o_v = 1'b0;
      end
      @(negedge clk);
      src0_valid = 1'b0; src1_valid = 1'b0;
      chk("WE3", WE3, o_v);
      chk("ad3", ad3, o_rd);
      chk("WD3", WD3, o_d);
      chk("count", count, sb.size());
      exp_lk(ad1, ep, ef);
      chk("pend1", pend1, ep);
      chk("fwd1", fwd1, ef);
      exp_lk(ad2, ep, ef);
      chk("pend2", pend2, ep);
      chk("fwd2", fwd2, ef);
   endtask

   initial begin
      tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 0};
      tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 32'hDEADBEEF, 0};
      tbl[2] = '{1'b1, 5'd3, 32'h1,        1'b1, 5'd4, 32'h2, 1'b1, 5'd3, 32'h1,        1};
      tbl[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h2,        0};
      tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 32'h2,        0};
      tbl[5] = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0, 1'b0, 5'd4, 32'h2,        0};
      tbl[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h66, 1'b0, 5'd4, 32'h2,       0};
      tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h99,      0};
      tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 32'h99,       0};

      rst = 1'b1;
      src0_valid = 0; src1_valid = 0; src0_rd = 0; src1_rd = 0;
      src0_data = 0; src1_data = 0; ad1 = 0; ad2 = 0;
      o_v = 0; o_rd = 0; o_d = 0;
      repeat (2) @(negedge clk);
      chk("rst_WE3", WE3, 0);
      chk("rst_ad3", ad3, 0);
      chk("rst_WD3", WD3, 0);
      chk("rst_count", count, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed table: single write, pair, rd==0 drops, lone src1
      ad1 = 5'd5; ad2 = 5'd4;
      for (int k = 0; k < 9; k++) begin
         tick(tbl[k].v0, tbl[k].r0, tbl[k].d0, tbl[k].v1, tbl[k].r1, tbl[k].d1);
         chk($sformatf("tbl%0d_we", k), WE3, tbl[k].e_we);
         chk($sformatf("tbl%0d_ad", k), ad3, tbl[k].e_ad);
         chk($sformatf("tbl%0d_wd", k), WD3, tbl[k].e_wd);
         chk($sformatf("tbl%0d_cnt", k), count, tbl[k].e_cnt);
      end

      // Both sources every cycle: occupancy climbs and src1 backs off at DEPTH-1
      ad1 = 5'd7; ad2 = 5'd8;
      for (int k = 0; k < 3; k++)
         tick(1'b1, 5'(10 + 2*k), 32'h100 + k, 1'b1, 5'(11 + 2*k), 32'h200 + k);
      chk("fill_count", count, 3);
      tick(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
      tick(1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h22);
      chk("fwd_pend1", pend1, 1);
      chk("fwd_fwd1", fwd1, 32'h22);
      chk("fwd_pend2", pend2, 0);
      chk("fwd_fwd2", fwd2, 0);
      for (int k = 0; k < 6; k++) tick(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk("drain_pend1", pend1, 0);
      chk("drain_we", WE3, 0);

      // Async reset with a busy queue
      for (int k = 0; k < 3; k++)
         tick(1'b1, 5'(20 + k), 32'h300 + k, 1'b1, 5'(24 + k), 32'h400 + k);
      chk("pre_rst_we", WE3, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_WE3", WE3, 0);
      chk("async_count", count, 0);
      @(posedge clk);
      #2 rst = 1'b0;
      sb.delete(); o_v = 0; o_rd = 0; o_d = 0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) tick(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Random traffic over a small register range to exercise overwrite/forwarding
      for (int k = 0; k < 200; k++) begin
         ad1 = 5'($urandom_range(0, 7));
         ad2 = 5'($urandom_range(0, 7));
         tick(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom);
      end
      for (int k = 0; k < 8; k++) tick(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
